sevenseg_capture: RTL and testbench
===================================

Name: sevenseg_capture

Overview:
Reverse direction of our hex-to-seven-segment encoder. The block samples a multiplexed seven-segment bus, which is segment lines plus one-hot digit strobes, for example from an external display driver or our own display path in loopback. It debounces each digit's pattern over consecutive samples and decodes it back to a 4-bit hex value per digit. Its outputs feed the self-check and readback logic.

Parameters:
DIGITS, 4, number of multiplexed digits (range 1..8)
STABLE_CNT, 3, consecutive identical samples required before a digit commits (range 1..15)
ACTIVE_LOW, 0, 1 = seg_in is active-low and is inverted before any processing

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  reset; asynchronous, active-high
seg_in  input  7  segment lines; bit0=A, bit1=B, … bit6=G
dig_en  input  DIGITS  digit strobe; only one-hot values are acted on
sample  input  1  qualifier; seg_in and dig_en are examined only in cycles where sample=1
nibbles  output  4*DIGITS  decoded value; digit k occupies bits [4k+3:4k]
valid  output  DIGITS  digit k currently shows a legal hex glyph
update  output  1  one-cycle pulse when any digit's nibble or valid changes
err  output  1  one-cycle pulse on an illegal committed glyph or a multi-hot dig_en

Behaviour:
- Reset (async assert, sync release): nibbles=0, valid=0, update=0, err=0. All per-digit candidate patterns=0 and match counters=0.
- Normalisation: pat = ACTIVE_LOW ? ~seg_in : seg_in.
- Accepted sample: sample=1 and dig_en has exactly one bit set, say bit k. Only digit k state is touched.
  - pat == cand[k]: cnt[k] increments, saturating at STABLE_CNT.
  - pat != cand[k]: cand[k]<=pat and cnt[k]<=1.
  - Commit fires when cnt[k] becomes STABLE_CNT on this sample. Saturated repeats do not re-commit.
  - With STABLE_CNT=1, every sample carrying a new pattern commits immediately.
- Decode table on commit (pat -> nibble):
  - 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7
  - 0x7F->8, 0x6F->9, 0x77->A, 0x7C->b, 0x39->C, 0x5E->d, 0x79->E, 0x71->F
- Commit results:
  - Legal glyph: nibble[k]<=decoded value, valid[k]<=1.
  - Blank (0x00): nibble[k]<=0, valid[k]<=0, no err.
  - Any other pattern: valid[k]<=0, nibble[k] retains its previous value, err pulses.
- Outputs are registered. A commit on the sample at edge n is visible after edge n+1, i.e. one cycle of latency.
- update pulses only if nibble[k] or valid[k] actually changes. Re-committing an identical value produces no pulse.
- sample=1 with dig_en zero: ignored silently.
- sample=1 with dig_en multi-hot: ignored, no per-digit state changes, err pulses.
- sample=0: no state changes. Counters persist across gaps, so scanned digits debounce independently while the bus cycles through the other digits.
- err and update are each a single-cycle pulse per triggering sample; they are never sticky.
- Reset mid-debounce discards all partial counts. The full STABLE_CNT samples are required again after reset.

Test Plan:
1. Reset, then three samples of seg_in=0x5B, dig_en=0001 -> cycle after third: nibbles[3:0]=2, valid=0001, update high for exactly 1 cycle; a fourth identical sample gives no further update.
2. Digit 0 glitch sequence 0x06,0x06,0x07,0x07,0x07 -> the 1 never commits; after the fifth sample nibbles[3:0]=7 and valid[0]=1.
3. Digit 0 holds 7, then 0x7E sampled three times -> err pulses 1 cycle, valid[0]=0, nibbles[3:0] stays 7, update pulses; then 0x00 x3 -> nibbles[3:0]=0, valid[0]=0, no err.
4. ACTIVE_LOW=1: seg_in=0x40 (inverse of 0x3F) on dig_en=0100 x3, interleaved with digit 0 samples of ~0x4F x3 -> nibbles=16'h0003 with digit2=0, valid=0101.
5. sample=1 with dig_en=0011 -> err 1-cycle pulse, no change to nibbles/valid/counters; dig_en=0000 -> no err, no change.
6. Two matching 0x6D samples on digit 1, then rst pulse, then one more 0x6D -> all outputs 0 during reset; no commit until three post-reset samples, after which nibbles[7:4]=5.

Source files
------------

// File: rtl/sevenseg_capture.sv
// Seven-segment bus capture: per-digit debounce and glyph-to-hex decode.
// Stage 1 debounces per digit; stage 2 decodes commits into registered outputs.
module sevenseg_capture #(
   parameter int DIGITS     = 4,
   parameter int STABLE_CNT = 3,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     dig_en,
   input  logic                  sample,
   output logic [4*DIGITS-1:0]   nibbles,
   output logic [DIGITS-1:0]     valid,
   output logic                  update,
   output logic                  err
);

   localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [3:0] SC = 4'(STABLE_CNT);

   logic [6:0]  pat;
   logic [3:0]  ones;
   logic [KW-1:0] k;
   logic        accept;
   logic        multi;
   logic        hit;
   logic        fire;
   logic [6:0]  cand [DIGITS];
   logic [3:0]  cnt  [DIGITS];

   logic        p_fire;
   logic        p_multi;
   logic [KW-1:0] p_k;
   logic [6:0]  p_pat;

   logic [DIGITS-1:0][3:0] nib_q;
   logic        dlegal;
   logic [3:0]  dnib;

   assign pat = (ACTIVE_LOW != 0) ? ~seg_in : seg_in;

   always_comb begin
      ones = '0;
      k    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_en[i]) begin
            ones = ones + 4'd1;
            k    = KW'(i);
         end
      end
   end

   assign accept = sample && (ones == 4'd1);
   assign multi  = sample && (ones > 4'd1);
   assign hit    = (cand[k] == pat);
   // commit exactly on the sample that brings the count up to threshold
   assign fire   = accept && (hit ? (cnt[k] == SC - 4'd1) : (SC == 4'd1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DIGITS; i++) begin
            cand[i] <= '0;
            cnt[i]  <= '0;
         end
         p_fire  <= 1'b0;
         p_multi <= 1'b0;
         p_k     <= '0;
         p_pat   <= '0;
      end else begin
         p_fire  <= fire;
         p_multi <= multi;
         p_k     <= k;
         p_pat   <= pat;
         if (accept) begin
            if (hit) begin
               if (cnt[k] < SC) cnt[k] <= cnt[k] + 4'd1;
            end else begin
               cand[k] <= pat;
               cnt[k]  <= 4'd1;
            end
         end
      end
   end

   always_comb begin
      dlegal = 1'b1;
      dnib   = 4'h0;
      case (p_pat)
         7'h3F: dnib = 4'h0;
         7'h06: dnib = 4'h1;
         7'h5B: dnib = 4'h2;
         7'h4F: dnib = 4'h3;
         7'h66: dnib = 4'h4;
         7'h6D: dnib = 4'h5;
         7'h7D: dnib = 4'h6;
         7'h07: dnib = 4'h7;
         7'h7F: dnib = 4'h8;
         7'h6F: dnib = 4'h9;
         7'h77: dnib = 4'hA;
         7'h7C: dnib = 4'hB;
         7'h39: dnib = 4'hC;
         7'h5E: dnib = 4'hD;
         7'h79: dnib = 4'hE;
         7'h71: dnib = 4'hF;
         default: dlegal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nib_q  <= '0;
         valid  <= '0;
         update <= 1'b0;
         err    <= 1'b0;
      end else begin
         update <= 1'b0;
         err    <= p_multi;
         if (p_fire) begin
            if (dlegal) begin
               nib_q[p_k] <= dnib;
               valid[p_k] <= 1'b1;
               update     <= !valid[p_k] || (nib_q[p_k] != dnib);
            end else if (p_pat == 7'h00) begin
               nib_q[p_k] <= 4'h0;
               valid[p_k] <= 1'b0;
               update     <= valid[p_k] || (nib_q[p_k] != 4'h0);
            end else begin
               // illegal glyph keeps the last good nibble for readback
               valid[p_k] <= 1'b0;
               err        <= 1'b1;
               update     <= valid[p_k];
            end
         end
      end
   end

   assign nibbles = nib_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: directed plan steps then random bus traffic.
// An active-low twin sees the inverted bus and must match the same model.
module tb_sevenseg_capture;

   localparam int D  = 4;
   localparam int SC = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sample = 1'b0;
   logic [6:0] seg = '0;
   logic [6:0] seg_n;
   logic [D-1:0] en = '0;

   logic [4*D-1:0] nib_a, nib_b;
   logic [D-1:0] val_a, val_b;
   logic upd_a, upd_b, err_a, err_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;
   assign seg_n = ~seg;

   sevenseg_capture #(.DIGITS(D), .STABLE_CNT(SC), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .seg_in(seg), .dig_en(en), .sample(sample),
      .nibbles(nib_a), .valid(val_a), .update(upd_a), .err(err_a)
   );

   sevenseg_capture #(.DIGITS(D), .STABLE_CNT(SC), .ACTIVE_LOW(1)) dut_n (
      .clk(clk), .rst(rst), .seg_in(seg_n), .dig_en(en), .sample(sample),
      .nibbles(nib_b), .valid(val_b), .update(upd_b), .err(err_b)
   );

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                              7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                              7'h39, 7'h5E, 7'h79, 7'h71};

   // reference: per-digit candidate/run length, plus one pending commit event
   logic [6:0] m_cand [D];
   int         m_run  [D];
   logic [3:0] e_nib  [D];
   logic       e_val  [D];
   logic       e_upd, e_err;
   bit         pv_fire, pv_bad;
   int         pv_k;
   logic [6:0] pv_pat;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < D; i++) begin
         m_cand[i] = '0;
         m_run[i]  = 0;
         e_nib[i]  = '0;
         e_val[i]  = 1'b0;
      end
      e_upd = 0; e_err = 0;
      pv_fire = 0; pv_bad = 0; pv_k = 0; pv_pat = '0;
   endtask

   task automatic model_edge();
      int g;
      int n;
      int j;
      logic [3:0] nn;
      logic nv;
      e_upd = 1'b0;
      e_err = pv_bad;
      if (pv_fire) begin
         g = -1;
         for (int i = 0; i < 16; i++) if (glyph[i] == pv_pat) g = i;
         if (g >= 0) begin
            nn = 4'(g); nv = 1'b1;
         end else if (pv_pat == 7'h00) begin
            nn = 4'h0; nv = 1'b0;
         end else begin
            nn = e_nib[pv_k]; nv = 1'b0; e_err = 1'b1;
         end
         if (nn != e_nib[pv_k] || nv != e_val[pv_k]) e_upd = 1'b1;
         e_nib[pv_k] = nn;
         e_val[pv_k] = nv;
      end
      pv_fire = 0; pv_bad = 0;
      if (sample) begin
         n = 0; j = 0;
         for (int i = 0; i < D; i++) if (en[i]) begin n++; j = i; end
         if (n > 1) pv_bad = 1;
         else if (n == 1) begin
            pv_k = j; pv_pat = seg;
            if (seg == m_cand[j]) begin
               if (m_run[j] < SC) begin
                  m_run[j]++;
                  if (m_run[j] == SC) pv_fire = 1;
               end
            end else begin
               m_cand[j] = seg;
               m_run[j] = 1;
               if (SC == 1) pv_fire = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      logic [4*D-1:0] en_v;
      logic [D-1:0] ev;
      for (int i = 0; i < D; i++) begin
         en_v[4*i +: 4] = e_nib[i];
         ev[i] = e_val[i];
      end
      chk("nibbles", 32'(nib_a), 32'(en_v));
      chk("valid", 32'(val_a), 32'(ev));
      chk("update", 32'(upd_a), 32'(e_upd));
      chk("err", 32'(err_a), 32'(e_err));
      chk("nibbles_al", 32'(nib_b), 32'(en_v));
      chk("valid_al", 32'(val_b), 32'(ev));
      chk("update_al", 32'(upd_b), 32'(e_upd));
      chk("err_al", 32'(err_b), 32'(e_err));
   endtask

   task automatic step(input logic [6:0] s, input logic [D-1:0] e,
                       input logic smp);
      seg = s; en = e; sample = smp;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      step(7'h00, '0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;
   endtask

   function automatic logic [6:0] pick_pat();
      int r;
      r = $urandom_range(0, 19);
      if (r < 16) return glyph[r];
      if (r == 16) return 7'h00;
      if (r == 17) return 7'h7E;
      if (r == 18) return 7'h01;
      return 7'h48;
   endfunction

   logic [6:0] hold [D];

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // 1: three 2s commit, fourth repeat is silent
      repeat (3) step(7'h5B, 4'b0001, 1'b1);
      step(7'h5B, 4'b0001, 1'b1);
      chk("t1_nib0", 32'(nib_a[3:0]), 32'h2);
      chk("t1_upd", 32'(upd_a), 32'h1);
      idle();
      chk("t1_noupd", 32'(upd_a), 32'h0);

      // 2: glitchy 1 never commits, 7 does
      step(7'h06, 4'b0001, 1'b1);
      step(7'h06, 4'b0001, 1'b1);
      repeat (3) step(7'h07, 4'b0001, 1'b1);
      idle();
      chk("t2_nib0", 32'(nib_a[3:0]), 32'h7);

      // 3: illegal glyph then blank
      repeat (3) step(7'h7E, 4'b0001, 1'b1);
      idle();
      chk("t3_err", 32'(err_a), 32'h1);
      chk("t3_keep", 32'(nib_a[3:0]), 32'h7);
      repeat (3) step(7'h00, 4'b0001, 1'b1);
      idle();

      // 4: digits 2 and 0 interleaved
      repeat (3) begin
         step(7'h3F, 4'b0100, 1'b1);
         step(7'h4F, 4'b0001, 1'b1);
      end
      idle();
      chk("t4_nib", 32'(nib_b), 32'h0003);
      chk("t4_val", 32'(val_b), 32'b0101);

      // 5: multi-hot flags err, zero strobe is ignored
      step(7'h3F, 4'b0011, 1'b1);
      idle();
      chk("t5_err", 32'(err_a), 32'h1);
      step(7'h3F, 4'b0000, 1'b1);
      idle();

      // 6: reset discards partial debounce
      repeat (2) step(7'h6D, 4'b0010, 1'b1);
      do_reset();
      repeat (3) step(7'h6D, 4'b0010, 1'b1);
      idle();
      chk("t6_nib1", 32'(nib_a[7:4]), 32'h5);

      // random bus traffic
      for (int i = 0; i < D; i++) hold[i] = pick_pat();
      for (int c = 0; c < 800; c++) begin
         int r;
         int j;
         logic [D-1:0] e;
         logic [6:0] s;
         if ($urandom_range(0, 199) == 0) do_reset();
         r = $urandom_range(0, 99);
         j = $urandom_range(0, D - 1);
         if (r < 85) begin
            e = '0; e[j] = 1'b1;
            if ($urandom_range(0, 3) == 0) hold[j] = pick_pat();
            s = hold[j];
         end else if (r < 92) begin
            e = '0; s = pick_pat();
         end else begin
            e = '0; e[j] = 1'b1; e[(j + 1) % D] = 1'b1;
            s = pick_pat();
         end
         step(s, e, ($urandom_range(0, 4) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
